fpu_rr_issue_arbiter: RTL and testbench
=======================================

// Module: fpu_rr_issue_arbiter
// PURPOSE
//   Shares one fixed-latency FPU pipeline between N_REQ requesters. Round-robin arbiter
//   issues one op/cycle to the FPU, tracks the requester ID of each in-flight op in a
//   FPU_LAT-deep tag pipe, and routes each result back. Sits between client engines and fpu_top;
//   flags FPU result-valid timing violations. Operands/results are fpu_pack::real_t.
// PARAMETERS
//   N_REQ    4  number of requesters (>=2)
//   N_ARG    2  operands per op
//   OP_W     4  opcode width
//   FPU_LAT  5  FPU cycles from fpu_valid to fpu_rez_valid (>=1)
//   MAX_OUT  4  max in-flight ops per requester (>=1)
// PORTS
//   clk            in   1                 clock
//   rst_n          in   1                 async active-low reset
//   req_valid      in   N_REQ             per-requester op request
//   req_ready      out  N_REQ             one-hot accept (comb.)
//   req_op         in   N_REQ*OP_W        per-requester opcode
//   req_arg        in   N_REQ*N_ARG real_t per-requester operands
//   fpu_valid      out  1                 op issued to FPU
//   fpu_op         out  OP_W              issued opcode
//   fpu_arg        out  N_ARG real_t      issued operands
//   fpu_rez_valid  in   1                 FPU result valid
//   fpu_rez        in   real_t            FPU result
//   rsp_valid      out  N_REQ             one-hot result strobe
//   rsp_rez        out  real_t            result (shared bus)
//   err_o          out  1                 sticky timing-violation flag
// BEHAVIOUR
//   - Connect clk/rst_n to fpu_top as well. rst_n=0 async clears: fpu_valid, rsp_valid,
//     err_o = 0; fpu_op/fpu_arg/rsp_rez = 0; RR pointer = N_REQ-1; tag pipe empty;
//     outstanding counters = 0. Ops in flight at reset are dropped.
//   - Eligible i: req_valid[i] && outst[i] < MAX_OUT. Grant: first eligible index scanning
//     ptr+1, ptr+2, ... (mod N_REQ). req_ready = one-hot grant, zero if none eligible.
//     Requester holds valid/op/arg stable until accepted. ptr <= granted index on accept only.
//   - Issue: accept in cycle t -> fpu_valid=1 with registered op/arg in t+1; fpu_valid=0
//     when no accept. Max throughput 1 op/cycle. No FPU backpressure.
//   - Tag pipe: FPU_LAT stages of {vld, id[$clog2(N_REQ)]}; stage0 loads {fpu_valid, id}.
//     Expected result at cycle t+1+FPU_LAT; tail stage aligns with fpu_rez_valid.
//   - Response: tail.vld && fpu_rez_valid -> next cycle rsp_valid[id]=1, rsp_rez=fpu_rez
//     (accept->rsp latency = FPU_LAT+2). rsp_rez holds last value when rsp_valid=0.
//     Requesters cannot stall responses.
//   - outst[i], width $clog2(MAX_OUT+1): +1 on accept of i, -1 when rsp_valid[i] issued;
//     both same cycle -> unchanged. Never wraps (MAX_OUT gate); at MAX_OUT i is skipped,
//     RR continues to next eligible.
//   - Violation: tail.vld != fpu_rez_valid -> err_o<=1 (sticky until rst_n). Missing result:
//     no rsp, counter still decremented. Unexpected result: discarded.
// TESTING
//   1 Reset: rst_n=0 mid-stream -> all outputs 0 same cycle; after release first accept is req0.
//   2 All 4 valid continuously, FPU model LAT=5 -> grants 0,1,2,3,0...; rsp_valid[k] 7 cycles
//     after each accept with matching result; fpu_valid=1 every cycle.
//   3 Only req2 valid, FPU stalled-free, MAX_OUT=4 -> 4 accepts back-to-back, ready drops
//     until first rsp, then 1 accept on that same cycle per response.
//   4 Sparse: req1 at t=0, req3 at t=3 -> independent issue, correct routing, err_o=0.
//   5 Model asserts fpu_rez_valid at LAT=4 -> err_o=1 and stays; no rsp for that op.
//   6 Simultaneous accept+rsp for same requester at outst=MAX_OUT-1 -> counter unchanged.

Source files
------------

// File: rtl/fpu_rr_issue_arbiter.sv
// Round-robin issue arbiter that shares one fixed-latency FPU between N_REQ requesters.
// A tag pipe follows each in-flight op so its result returns to the requester that issued it.
module fpu_rr_issue_arbiter #(
    parameter int N_REQ   = 4,
    parameter int N_ARG   = 2,
    parameter int OP_W    = 4,
    parameter int FPU_LAT = 5,
    parameter int MAX_OUT = 4,
    parameter int DATA_W  = 64   // width of fpu_pack::real_t
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ*OP_W-1:0]         req_op,
    input  logic [N_REQ*N_ARG*DATA_W-1:0] req_arg,
    output logic                          fpu_valid,
    output logic [OP_W-1:0]               fpu_op,
    output logic [N_ARG*DATA_W-1:0]       fpu_arg,
    input  logic                          fpu_rez_valid,
    input  logic [DATA_W-1:0]             fpu_rez,
    output logic [N_REQ-1:0]              rsp_valid,
    output logic [DATA_W-1:0]             rsp_rez,
    output logic                          err_o
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam int ARG_W = N_ARG * DATA_W;

    logic [ID_W-1:0]   r_ptr;
    logic              r_fpuValid;
    logic [OP_W-1:0]   r_fpuOp;
    logic [ARG_W-1:0]  r_fpuArg;
    logic [ID_W-1:0]   r_issueId;
    logic [FPU_LAT-1:0] r_tagVld;
    logic [ID_W-1:0]   r_tagId [FPU_LAT];
    logic [CNT_W-1:0]  r_outst [N_REQ];
    logic [N_REQ-1:0]  r_rspValid;
    logic [DATA_W-1:0] r_rspRez;
    logic              r_err;

    logic [N_REQ-1:0]  w_elig;
    logic [N_REQ-1:0]  w_grant;
    logic [ID_W-1:0]   w_grantId;
    logic              w_accept;
    logic              w_tailVld;
    logic [ID_W-1:0]   w_tailId;

    function automatic logic [ID_W-1:0] scanIdx(input logic [ID_W-1:0] ptr, input int k);
        int sum;
        sum = (int'(ptr) + k) % N_REQ;
        return ID_W'(sum);
    endfunction

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_elig[i] = req_valid[i] && (r_outst[i] < CNT_W'(MAX_OUT));
        end
    end

    // Scan starts just past the last winner, so the previous grantee has lowest priority.
    always_comb begin
        w_grant   = '0;
        w_grantId = '0;
        w_accept  = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!w_accept && w_elig[scanIdx(r_ptr, k)]) begin
                w_accept  = 1'b1;
                w_grantId = scanIdx(r_ptr, k);
            end
        end
        w_grant[w_grantId] = w_accept;
    end

    assign req_ready = w_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= ID_W'(N_REQ - 1);
            r_fpuValid <= 1'b0;
            r_fpuOp    <= '0;
            r_fpuArg   <= '0;
            r_issueId  <= '0;
        end else begin
            r_fpuValid <= w_accept;
            if (w_accept) begin
                r_ptr     <= w_grantId;
                r_issueId <= w_grantId;
                r_fpuOp   <= req_op[int'(w_grantId)*OP_W +: OP_W];
                r_fpuArg  <= req_arg[int'(w_grantId)*ARG_W +: ARG_W];
            end
        end
    end

    assign fpu_valid = r_fpuValid;
    assign fpu_op    = r_fpuOp;
    assign fpu_arg   = r_fpuArg;

    // The tail stage lines up with the cycle the FPU should raise fpu_rez_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tagVld <= '0;
            for (int s = 0; s < FPU_LAT; s++) begin
                r_tagId[s] <= '0;
            end
        end else begin
            r_tagVld[0] <= r_fpuValid;
            r_tagId[0]  <= r_issueId;
            for (int s = 1; s < FPU_LAT; s++) begin
                r_tagVld[s] <= r_tagVld[s-1];
                r_tagId[s]  <= r_tagId[s-1];
            end
        end
    end

    assign w_tailVld = r_tagVld[FPU_LAT-1];
    assign w_tailId  = r_tagId[FPU_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rspValid <= '0;
            r_rspRez   <= '0;
            r_err      <= 1'b0;
        end else begin
            r_rspValid <= '0;
            if (w_tailVld && fpu_rez_valid) begin
                r_rspValid[w_tailId] <= 1'b1;
                r_rspRez             <= fpu_rez;
            end
            if (w_tailVld != fpu_rez_valid) begin
                r_err <= 1'b1;
            end
        end
    end

    assign rsp_valid = r_rspValid;
    assign rsp_rez   = r_rspRez;
    assign err_o     = r_err;

    // Retire on the tail tag rather than on the response, so a lost result still frees its slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REQ; i++) begin
                r_outst[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                case ({w_grant[i], w_tailVld && (w_tailId == ID_W'(i))})
                    2'b10:   r_outst[i] <= r_outst[i] + CNT_W'(1);
                    2'b01:   r_outst[i] <= r_outst[i] - CNT_W'(1);
                    default: r_outst[i] <= r_outst[i];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fpu_rr_issue_arbiter.sv
// Directed bench for fpu_rr_issue_arbiter with a behavioural FPU whose latency can be skewed.
// Each test task drives a scenario cycle by cycle and compares against hand-derived values.
module tb_fpu_rr_issue_arbiter;

    localparam int N_REQ   = 4;
    localparam int N_ARG   = 2;
    localparam int OP_W    = 4;
    localparam int DATA_W  = 64;

    logic                          clk;
    logic                          rst_n;
    logic [N_REQ-1:0]              req_valid;
    logic [N_REQ-1:0]              req_ready;
    logic [N_REQ*OP_W-1:0]         req_op;
    logic [N_REQ*N_ARG*DATA_W-1:0] req_arg;
    logic                          fpu_valid;
    logic [OP_W-1:0]               fpu_op;
    logic [N_ARG*DATA_W-1:0]       fpu_arg;
    logic                          fpu_rez_valid;
    logic [DATA_W-1:0]             fpu_rez;
    logic [N_REQ-1:0]              rsp_valid;
    logic [DATA_W-1:0]             rsp_rez;
    logic                          err_o;

    int checkCount = 0;
    int passCount  = 0;

    logic [7:0]        mVld;
    logic [DATA_W-1:0] mRez [8];
    logic [2:0]        modelTap;

    fpu_rr_issue_arbiter #(
        .N_REQ(N_REQ), .N_ARG(N_ARG), .OP_W(OP_W), .FPU_LAT(5), .MAX_OUT(4), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_arg(req_arg),
        .fpu_valid(fpu_valid), .fpu_op(fpu_op), .fpu_arg(fpu_arg),
        .fpu_rez_valid(fpu_rez_valid), .fpu_rez(fpu_rez),
        .rsp_valid(rsp_valid), .rsp_rez(rsp_rez), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] opOf(input int k);
        return 4'(k + 1);
    endfunction
    function automatic logic [63:0] arg0Of(input int k);
        return 64'(k + 1) << 12;
    endfunction
    function automatic logic [63:0] arg1Of(input int k);
        return 64'(3 * k + 7);
    endfunction
    function automatic logic [63:0] rezOf(input int k);
        return arg0Of(k) + arg1Of(k) + 64'(opOf(k));
    endfunction

    // FPU model: result = arg0 + arg1 + op, valid modelTap+1 cycles after fpu_valid.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mVld <= '0;
            for (int i = 0; i < 8; i++) mRez[i] <= '0;
        end else begin
            for (int i = 7; i > 0; i--) begin
                mVld[i] <= mVld[i-1];
                mRez[i] <= mRez[i-1];
            end
            mVld[0] <= fpu_valid;
            mRez[0] <= fpu_arg[63:0] + fpu_arg[127:64] + 64'(fpu_op);
        end
    end

    assign fpu_rez_valid = mVld[modelTap];
    assign fpu_rez       = mRez[modelTap];

    task automatic test_reset;
        rst_n = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkCount++; if (fpu_valid !== 1'b0) $display("[TB] FAIL rst_fpu_valid got=%b exp=0", fpu_valid); else passCount++;
        checkCount++; if (rsp_valid !== 4'b0) $display("[TB] FAIL rst_rsp_valid got=%b exp=0000", rsp_valid); else passCount++;
        checkCount++; if (err_o !== 1'b0) $display("[TB] FAIL rst_err got=%b exp=0", err_o); else passCount++;
        checkCount++; if (fpu_op !== 4'h0) $display("[TB] FAIL rst_fpu_op got=%h exp=0", fpu_op); else passCount++;
        checkCount++; if (fpu_arg !== '0) $display("[TB] FAIL rst_fpu_arg got=%h exp=0", fpu_arg); else passCount++;
        checkCount++; if (rsp_rez !== '0) $display("[TB] FAIL rst_rsp_rez got=%h exp=0", rsp_rez); else passCount++;

        @(posedge clk); #1;
        rst_n = 1'b1;
        req_valid = 4'hF;
        repeat (9) @(posedge clk);
        #2;
        checkCount++; if (rsp_valid !== 4'b0100) $display("[TB] FAIL mid_rsp_valid got=%b exp=0100", rsp_valid); else passCount++;
        checkCount++; if (rsp_rez !== rezOf(2)) $display("[TB] FAIL mid_rsp_rez got=%h exp=%h", rsp_rez, rezOf(2)); else passCount++;
        checkCount++; if (fpu_valid !== 1'b1) $display("[TB] FAIL mid_fpu_valid got=%b exp=1", fpu_valid); else passCount++;

        rst_n = 1'b0;
        #1;
        checkCount++; if (fpu_valid !== 1'b0) $display("[TB] FAIL async_fpu_valid got=%b exp=0", fpu_valid); else passCount++;
        checkCount++; if (rsp_valid !== 4'b0) $display("[TB] FAIL async_rsp_valid got=%b exp=0000", rsp_valid); else passCount++;
        checkCount++; if (fpu_op !== 4'h0) $display("[TB] FAIL async_fpu_op got=%h exp=0", fpu_op); else passCount++;
        checkCount++; if (fpu_arg !== '0) $display("[TB] FAIL async_fpu_arg got=%h exp=0", fpu_arg); else passCount++;
        checkCount++; if (rsp_rez !== '0) $display("[TB] FAIL async_rsp_rez got=%h exp=0", rsp_rez); else passCount++;
        checkCount++; if (err_o !== 1'b0) $display("[TB] FAIL async_err got=%b exp=0", err_o); else passCount++;

        req_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        req_valid = 4'hF;
        #1;
        checkCount++; if (req_ready !== 4'b0001) $display("[TB] FAIL post_rst_first_grant got=%b exp=0001", req_ready); else passCount++;
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_round_robin;
        logic [3:0] expReady;
        logic [3:0] expRsp;
        logic       expFv;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            req_valid = (n < 12) ? 4'hF : 4'h0;
            @(negedge clk);
            expReady = (n < 12) ? 4'(1 << (n % 4)) : 4'h0;
            expFv    = (n >= 1) && (n <= 12);
            expRsp   = (n >= 7) && (n <= 18) ? 4'(1 << ((n - 7) % 4)) : 4'h0;
            checkCount++; if (req_ready !== expReady) $display("[TB] FAIL rr_ready n=%0d got=%b exp=%b", n, req_ready, expReady); else passCount++;
            checkCount++; if (fpu_valid !== expFv) $display("[TB] FAIL rr_fpu_valid n=%0d got=%b exp=%b", n, fpu_valid, expFv); else passCount++;
            if (expFv) begin
                checkCount++; if (fpu_op !== opOf((n - 1) % 4)) $display("[TB] FAIL rr_fpu_op n=%0d got=%h exp=%h", n, fpu_op, opOf((n - 1) % 4)); else passCount++;
            end
            checkCount++; if (rsp_valid !== expRsp) $display("[TB] FAIL rr_rsp_valid n=%0d got=%b exp=%b", n, rsp_valid, expRsp); else passCount++;
            if (expRsp != 4'h0) begin
                checkCount++; if (rsp_rez !== rezOf((n - 7) % 4)) $display("[TB] FAIL rr_rsp_rez n=%0d got=%h exp=%h", n, rsp_rez, rezOf((n - 7) % 4)); else passCount++;
            end
        end
        checkCount++; if (err_o !== 1'b0) $display("[TB] FAIL rr_err got=%b exp=0", err_o); else passCount++;
    endtask

    // Also covers accept and retire of the same requester in one cycle at MAX_OUT-1.
    task automatic test_outstanding_limit;
        logic [3:0] expReady;
        logic [3:0] expRsp;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            req_valid = (n < 14) ? 4'b0100 : 4'b0000;
            @(negedge clk);
            expReady = (n < 14) && ((n % 7) < 4) ? 4'b0100 : 4'b0000;
            expRsp   = (n >= 7) && ((n % 7) < 4) ? 4'b0100 : 4'b0000;
            checkCount++; if (req_ready !== expReady) $display("[TB] FAIL lim_ready n=%0d got=%b exp=%b", n, req_ready, expReady); else passCount++;
            checkCount++; if (rsp_valid !== expRsp) $display("[TB] FAIL lim_rsp_valid n=%0d got=%b exp=%b", n, rsp_valid, expRsp); else passCount++;
            if (expRsp != 4'b0000) begin
                checkCount++; if (rsp_rez !== rezOf(2)) $display("[TB] FAIL lim_rsp_rez n=%0d got=%h exp=%h", n, rsp_rez, rezOf(2)); else passCount++;
            end
        end
    endtask

    task automatic test_sparse;
        logic [3:0] stim;
        logic [3:0] expRsp;
        logic       expFv;
        for (int n = 0; n < 13; n++) begin
            @(posedge clk); #1;
            stim = (n == 0) ? 4'b0010 : (n == 3) ? 4'b1000 : 4'b0000;
            req_valid = stim;
            @(negedge clk);
            expFv  = (n == 1) || (n == 4);
            expRsp = (n == 7) ? 4'b0010 : (n == 10) ? 4'b1000 : 4'b0000;
            checkCount++; if (req_ready !== stim) $display("[TB] FAIL sp_ready n=%0d got=%b exp=%b", n, req_ready, stim); else passCount++;
            checkCount++; if (fpu_valid !== expFv) $display("[TB] FAIL sp_fpu_valid n=%0d got=%b exp=%b", n, fpu_valid, expFv); else passCount++;
            checkCount++; if (rsp_valid !== expRsp) $display("[TB] FAIL sp_rsp_valid n=%0d got=%b exp=%b", n, rsp_valid, expRsp); else passCount++;
            if (n == 7) begin
                checkCount++; if (rsp_rez !== rezOf(1)) $display("[TB] FAIL sp_rsp_rez1 got=%h exp=%h", rsp_rez, rezOf(1)); else passCount++;
            end
            if (n == 12) begin
                checkCount++; if (rsp_rez !== rezOf(3)) $display("[TB] FAIL sp_rsp_rez_hold got=%h exp=%h", rsp_rez, rezOf(3)); else passCount++;
            end
        end
        checkCount++; if (err_o !== 1'b0) $display("[TB] FAIL sp_err got=%b exp=0", err_o); else passCount++;
    endtask

    task automatic test_timing_violation;
        logic expErr;
        modelTap = 3'd3;
        for (int n = 0; n < 16; n++) begin
            @(posedge clk); #1;
            req_valid = (n == 0) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            if (n == 0) begin
                checkCount++; if (req_ready !== 4'b0001) $display("[TB] FAIL tv_ready got=%b exp=0001", req_ready); else passCount++;
            end
            expErr = (n >= 6);
            checkCount++; if (err_o !== expErr) $display("[TB] FAIL tv_err n=%0d got=%b exp=%b", n, err_o, expErr); else passCount++;
            checkCount++; if (rsp_valid !== 4'b0000) $display("[TB] FAIL tv_rsp_valid n=%0d got=%b exp=0000", n, rsp_valid); else passCount++;
        end
        modelTap = 3'd4;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        modelTap  = 3'd4;
        for (int k = 0; k < N_REQ; k++) begin
            req_op[k*OP_W +: OP_W]                    = opOf(k);
            req_arg[(k*N_ARG)*DATA_W +: DATA_W]       = arg0Of(k);
            req_arg[(k*N_ARG + 1)*DATA_W +: DATA_W]   = arg1Of(k);
        end
        test_reset();
        test_round_robin();
        test_outstanding_limit();
        test_sparse();
        test_timing_violation();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
